// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI / internal register-file arbiter.
// Also holds the address range check used by both the SPI FSM and the arbiter.
package spi_reg_pkg;

  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 8;
  localparam int unsigned NUM_REGS = 128;
  localparam int RF_RD_LAT = 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_WAIT  = 3'd3,
    S_RD_HOLD  = 3'd4,
    S_WR_WAIT  = 3'd5,
    S_WR_ISSUE = 3'd6,
    S_DONE     = 3'd7
  } spi_fsm_t;

  typedef struct packed {
    logic              en;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } rf_cmd_t;

  localparam rf_cmd_t RF_CMD_IDLE = '{
    en:    1'b0,
    we:    1'b0,
    addr:  {ADDR_W{1'b0}},
    wdata: {DATA_W{1'b0}}
  };

  function automatic logic addr_oor(input logic [ADDR_W-1:0] addr,
                                    input int unsigned       num_regs);
    return (32'(addr) >= num_regs);
  endfunction

endpackage

// File: rtl/spi_reg_txn_fsm.sv
// Tracks one SPI register transaction: edge detection, state sequencing and
// the read data / valid level presented back to the SPI slave.
module spi_reg_txn_fsm
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = spi_reg_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_spi_start_flag,
  input  logic [ADDR_W-1:0] i_spi_addr,
  input  logic              i_spi_addr_valid,
  input  logic              i_spi_rw,
  input  logic              i_spi_wr_valid,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output spi_fsm_t          o_state,
  output logic [DATA_W-1:0] o_spi_rd_data,
  output logic              o_spi_rd_en
);

  spi_fsm_t          r_state;
  logic              r_addr_prev;
  logic              r_wr_prev;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_en;
  logic              w_addr_rise;
  logic              w_wr_rise;
  logic              w_oor;

  assign w_addr_rise = i_spi_addr_valid & ~r_addr_prev;
  assign w_wr_rise   = i_spi_wr_valid & ~r_wr_prev;
  assign w_oor       = addr_oor(i_spi_addr, NUM_REGS);

  // A new start pulse always restarts the transaction, whatever state we are in.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_addr_prev <= 1'b0;
      r_wr_prev   <= 1'b0;
      r_rd_data   <= {DATA_W{1'b0}};
      r_rd_en     <= 1'b0;
    end else begin
      r_addr_prev <= i_spi_addr_valid;
      r_wr_prev   <= i_spi_wr_valid;
      if (i_spi_start_flag) begin
        r_state   <= S_ADDR;
        r_rd_en   <= 1'b0;
        r_rd_data <= {DATA_W{1'b0}};
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_IDLE;
          S_ADDR: begin
            if (w_addr_rise) begin
              r_state <= i_spi_rw ? S_RD_ISSUE : S_WR_WAIT;
            end else begin
              r_state <= S_ADDR;
            end
          end
          S_RD_ISSUE: r_state <= S_RD_WAIT;
          S_RD_WAIT: begin
            r_rd_data <= w_oor ? {DATA_W{1'b0}} : i_rf_rdata;
            r_rd_en   <= 1'b1;
            r_state   <= S_RD_HOLD;
          end
          S_RD_HOLD: begin
            if (!i_spi_addr_valid) begin
              r_state <= S_IDLE;
              r_rd_en <= 1'b0;
            end else begin
              r_state <= S_RD_HOLD;
            end
          end
          // Losing addr_valid before the payload completes aborts the write.
          S_WR_WAIT: begin
            if (!i_spi_addr_valid) begin
              r_state <= S_IDLE;
            end else if (w_wr_rise) begin
              r_state <= S_WR_ISSUE;
            end else begin
              r_state <= S_WR_WAIT;
            end
          end
          S_WR_ISSUE: r_state <= S_DONE;
          S_DONE: begin
            if (!i_spi_addr_valid) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DONE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_state       = r_state;
  assign o_spi_rd_data = r_rd_data;
  assign o_spi_rd_en   = r_rd_en;

endmodule

// File: rtl/spi_reg_arbiter.sv
// Shares a single-port register file between the SPI slave (absolute priority)
// and an internal req/gnt requester with a fixed one-cycle read return.
module spi_reg_arbiter
  import spi_reg_pkg::*;
#(
  parameter int unsigned NUM_REGS = spi_reg_pkg::NUM_REGS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_start_flag,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic              spi_addr_valid,
  input  logic              spi_rw,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              spi_wr_valid,
  output logic [DATA_W-1:0] spi_rd_data,
  output logic              spi_rd_en,
  input  logic              int_req,
  input  logic              int_we,
  input  logic [ADDR_W-1:0] int_addr,
  input  logic [DATA_W-1:0] int_wdata,
  output logic              int_gnt,
  output logic              int_rvalid,
  output logic [DATA_W-1:0] int_rdata,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              err_addr
);

  spi_fsm_t             w_state;
  rf_cmd_t              w_cmd;
  logic                 w_spi_issue;
  logic                 w_spi_oor;
  logic                 w_int_oor;
  logic                 w_int_gnt;
  logic                 w_err;
  logic [RF_RD_LAT-1:0] r_rd_tag;
  logic [RF_RD_LAT-1:0] r_rd_zero;

  spi_reg_txn_fsm #(
    .NUM_REGS (NUM_REGS)
  ) u_txn_fsm (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_spi_start_flag (spi_start_flag),
    .i_spi_addr       (spi_addr),
    .i_spi_addr_valid (spi_addr_valid),
    .i_spi_rw         (spi_rw),
    .i_spi_wr_valid   (spi_wr_valid),
    .i_rf_rdata       (rf_rdata),
    .o_state          (w_state),
    .o_spi_rd_data    (spi_rd_data),
    .o_spi_rd_en      (spi_rd_en)
  );

  // Nothing reaches the register file while reset is asserted.
  assign w_spi_issue = reset_n & ((w_state == S_RD_ISSUE) | (w_state == S_WR_ISSUE));
  assign w_int_gnt   = reset_n & int_req & ~w_spi_issue;
  assign w_spi_oor   = addr_oor(spi_addr, NUM_REGS);
  assign w_int_oor   = addr_oor(int_addr, NUM_REGS);

  // Single command mux: SPI issue cycles win, internal fills every other cycle.
  always_comb begin
    w_cmd = RF_CMD_IDLE;
    w_err = 1'b0;
    if (w_spi_issue) begin
      if (w_spi_oor) begin
        w_err = 1'b1;
      end else begin
        w_cmd.en    = 1'b1;
        w_cmd.we    = (w_state == S_WR_ISSUE);
        w_cmd.addr  = spi_addr;
        w_cmd.wdata = spi_wr_data;
      end
    end else if (w_int_gnt) begin
      if (w_int_oor) begin
        w_err = 1'b1;
      end else begin
        w_cmd.en    = 1'b1;
        w_cmd.we    = int_we;
        w_cmd.addr  = int_addr;
        w_cmd.wdata = int_wdata;
      end
    end else begin
      w_cmd = RF_CMD_IDLE;
    end
  end

  // Return tag follows each granted internal read through the rf read latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rd_tag  <= {RF_RD_LAT{1'b0}};
      r_rd_zero <= {RF_RD_LAT{1'b0}};
    end else begin
      r_rd_tag[0]  <= w_int_gnt & ~int_we;
      r_rd_zero[0] <= w_int_oor;
      for (int i = 1; i < RF_RD_LAT; i++) begin
        r_rd_tag[i]  <= r_rd_tag[i-1];
        r_rd_zero[i] <= r_rd_zero[i-1];
      end
    end
  end

  assign rf_en      = w_cmd.en;
  assign rf_we      = w_cmd.we;
  assign rf_addr    = w_cmd.en ? w_cmd.addr : {ADDR_W{1'b0}};
  assign rf_wdata   = w_cmd.en ? w_cmd.wdata : {DATA_W{1'b0}};
  assign err_addr   = w_err;
  assign int_gnt    = w_int_gnt;
  assign int_rvalid = r_rd_tag[RF_RD_LAT-1];
  assign int_rdata  = (r_rd_tag[RF_RD_LAT-1] && !r_rd_zero[RF_RD_LAT-1]) ? rf_rdata
                                                                         : {DATA_W{1'b0}};

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Randomized bench for spi_reg_arbiter: an rf model plus a shadow register
// array that predicts every read, grant and rf command from intent.
module tb_spi_reg_arbiter;
  import spi_reg_pkg::*;

  localparam int unsigned NREGS = 64;

  logic       clk = 1'b0;
  logic       reset_n, spi_start_flag, spi_addr_valid, spi_rw, spi_wr_valid, spi_rd_en;
  logic       int_req, int_we, int_gnt, int_rvalid, rf_en, rf_we, err_addr;
  logic [6:0] spi_addr, int_addr, rf_addr;
  logic [7:0] spi_wr_data, spi_rd_data, int_wdata, int_rdata, rf_wdata, rf_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [0:127];
  logic [7:0] exp_mem [0:127];
  bit         int_pend, rd_pend, hold_prev, int_wr_ok;
  int         int_rate;
  logic [7:0] rd_exp, spi_exp;

  always #5 clk = ~clk;

  spi_reg_arbiter #(.NUM_REGS(NREGS)) dut (
    .clk(clk), .reset_n(reset_n), .spi_start_flag(spi_start_flag), .spi_addr(spi_addr),
    .spi_addr_valid(spi_addr_valid), .spi_rw(spi_rw), .spi_wr_data(spi_wr_data),
    .spi_wr_valid(spi_wr_valid), .spi_rd_data(spi_rd_data), .spi_rd_en(spi_rd_en),
    .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_gnt(int_gnt), .int_rvalid(int_rvalid), .int_rdata(int_rdata),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .err_addr(err_addr)
  );

  // Pipelined single-port register file with one-cycle read latency.
  always @(posedge clk) begin
    if (rf_en) begin
      if (rf_we) mem[rf_addr] = rf_wdata;
      else       rf_rdata <= mem[rf_addr];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic force_int(input logic we, input logic [6:0] a, input logic [7:0] d);
    int_req = 1'b1; int_we = we; int_addr = a; int_wdata = d; int_pend = 1'b1;
  endtask

  task automatic int_drive(input bit gen);
    if (!int_pend) begin
      if (gen && ($urandom_range(0, 99) < int_rate)) begin
        int_req   = 1'b1;
        int_we    = int_wr_ok ? 1'($urandom_range(0, 1)) : 1'b0;
        int_addr  = 7'($urandom_range(0, 79));
        int_wdata = 8'($urandom);
        int_pend  = 1'b1;
      end else begin
        int_req = 1'b0;
        int_we  = 1'b0;
      end
    end
  endtask

  // Internal side expectations for the current cycle; spi_issue marks an SPI-owned cycle.
  task automatic int_check(input bit spi_issue);
    bit g, oor;
    g   = int_pend && !spi_issue;
    oor = (32'(int_addr) >= NREGS);
    check_val("int_gnt", int_gnt, g);
    check_val("int_rvalid", int_rvalid, rd_pend);
    if (rd_pend) check_val("int_rdata", int_rdata, rd_exp);
    rd_pend = 1'b0;
    if (g) begin
      check_val("int_rf_en", rf_en, !oor);
      check_val("int_err", err_addr, oor);
      if (!oor) begin
        check_val("int_rf_we", rf_we, int_we);
        check_val("int_rf_addr", rf_addr, int_addr);
        if (int_we) check_val("int_rf_wdata", rf_wdata, int_wdata);
        if (int_we) exp_mem[int_addr] = int_wdata;
      end else begin
        check_val("int_rf_addr0", rf_addr, 32'd0);
      end
      if (!int_we) begin
        rd_pend = 1'b1;
        rd_exp  = oor ? 8'h00 : exp_mem[int_addr];
      end
      int_pend = 1'b0;
    end else if (!spi_issue) begin
      check_val("idle_rf_en", rf_en, 32'd0);
      check_val("idle_err", err_addr, 32'd0);
    end
  endtask

  task automatic spi_issue_check(input bit we, input logic [6:0] a, input logic [7:0] d);
    bit oor;
    oor = (32'(a) >= NREGS);
    check_val("spi_rf_en", rf_en, !oor);
    check_val("spi_err", err_addr, oor);
    if (!oor) begin
      check_val("spi_rf_we", rf_we, we);
      check_val("spi_rf_addr", rf_addr, a);
      if (we) check_val("spi_rf_wdata", rf_wdata, d);
      if (we) exp_mem[a] = d;
    end
    if (!we) spi_exp = oor ? 8'h00 : exp_mem[a];
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_rd_en"}, spi_rd_en, 32'd0);
    check_val({tag, "_rd_data"}, spi_rd_data, 32'd0);
    check_val({tag, "_gnt"}, int_gnt, 32'd0);
    check_val({tag, "_rvalid"}, int_rvalid, 32'd0);
    check_val({tag, "_rdata"}, int_rdata, 32'd0);
    check_val({tag, "_rf_en"}, rf_en, 32'd0);
    check_val({tag, "_rf_we"}, rf_we, 32'd0);
    check_val({tag, "_rf_addr"}, rf_addr, 32'd0);
    check_val({tag, "_rf_wdata"}, rf_wdata, 32'd0);
    check_val({tag, "_err"}, err_addr, 32'd0);
  endtask

  // SPI read: addr_rise at T, rf read at T+1, data and valid at T+3.
  task automatic spi_read(input logic [6:0] a, input bit force_rd, input bit keep);
    cyc(); spi_start_flag = 1'b1; spi_addr_valid = 1'b0; spi_wr_valid = 1'b0;
    int_drive(!force_rd); smp(); int_check(1'b0);
    check_val("rd_en_start", spi_rd_en, hold_prev);
    cyc(); spi_start_flag = 1'b0; spi_addr = a; spi_rw = 1'b1; spi_addr_valid = 1'b1;
    if (force_rd) force_int(1'b0, 7'h01, 8'h00); else int_drive(1'b1);
    smp(); int_check(1'b0);
    check_val("rd_en_T", spi_rd_en, 32'd0);
    check_val("rd_data_T", spi_rd_data, 32'd0);
    cyc(); if (force_rd) force_int(1'b0, 7'h02, 8'h00); else int_drive(1'b1);
    smp(); int_check(1'b1); spi_issue_check(1'b0, a, 8'h00);
    check_val("rd_en_T1", spi_rd_en, 32'd0);
    cyc(); int_drive(1'b1); smp(); int_check(1'b0);
    check_val("rd_en_T2", spi_rd_en, 32'd0);
    for (int k = 3; k <= 4; k++) begin
      cyc(); int_drive(1'b1); smp(); int_check(1'b0);
      check_val("rd_en_T3", spi_rd_en, 32'd1);
      check_val("rd_data_T3", spi_rd_data, spi_exp);
    end
    if (keep) begin
      hold_prev = 1'b1;
    end else begin
      cyc(); spi_addr_valid = 1'b0; int_drive(1'b1); smp(); int_check(1'b0);
      check_val("rd_en_hold", spi_rd_en, 32'd1);
      cyc(); int_drive(1'b1); smp(); int_check(1'b0);
      check_val("rd_en_end", spi_rd_en, 32'd0);
      hold_prev = 1'b0;
    end
  endtask

  task automatic spi_write(input logic [6:0] a, input logic [7:0] d, input bit abort, input bit conflict);
    cyc(); spi_start_flag = 1'b1; spi_addr_valid = 1'b0; spi_wr_valid = 1'b0;
    int_drive(1'b1); smp(); int_check(1'b0);
    check_val("wr_rd_en_start", spi_rd_en, hold_prev);
    hold_prev = 1'b0;
    cyc(); spi_start_flag = 1'b0; spi_addr = a; spi_rw = 1'b0; spi_addr_valid = 1'b1;
    int_drive(1'b1); smp(); int_check(1'b0);
    cyc(); int_drive(1'b1); smp(); int_check(1'b0);
    if (abort) begin
      cyc(); spi_addr_valid = 1'b0; int_drive(1'b1); smp(); int_check(1'b0);
      cyc(); spi_wr_data = d; spi_wr_valid = 1'b1; int_drive(1'b1); smp(); int_check(1'b0);
      cyc(); spi_wr_valid = 1'b0; int_drive(1'b1); smp(); int_check(1'b0);
    end else begin
      cyc(); spi_wr_data = d; spi_wr_valid = 1'b1; int_drive(!conflict); smp(); int_check(1'b0);
      cyc(); if (conflict) force_int(1'b1, a, 8'h77); else int_drive(1'b1);
      smp(); int_check(1'b1); spi_issue_check(1'b1, a, d);
      cyc(); int_drive(1'b1); smp(); int_check(1'b0);
      cyc(); spi_addr_valid = 1'b0; spi_wr_valid = 1'b0; int_drive(1'b1); smp(); int_check(1'b0);
      cyc(); int_drive(1'b1); smp(); int_check(1'b0);
    end
  endtask

  task automatic reset_mid_write();
    cyc(); spi_start_flag = 1'b1; spi_addr_valid = 1'b0; spi_wr_valid = 1'b0;
    int_drive(1'b1); smp(); int_check(1'b0);
    cyc(); spi_start_flag = 1'b0; spi_addr = 7'h20; spi_rw = 1'b0; spi_addr_valid = 1'b1;
    int_drive(1'b0); smp(); int_check(1'b0);
    cyc(); reset_n = 1'b0; int_drive(1'b0); smp(); int_check(1'b0);
    cyc(); spi_wr_data = 8'h99; spi_wr_valid = 1'b1;
    int_req = 1'b1; int_we = 1'b1; int_addr = 7'h21; int_wdata = 8'h55;
    smp(); check_all_zero("rst_mid");
    cyc(); reset_n = 1'b1; int_req = 1'b0; int_we = 1'b0; int_pend = 1'b0; rd_pend = 1'b0;
    smp(); int_check(1'b0);
    cyc(); spi_addr_valid = 1'b0; spi_wr_valid = 1'b0; smp(); int_check(1'b0);
    hold_prev = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 8'(i * 37 + 11);
      exp_mem[i] = 8'(i * 37 + 11);
    end
    mem[5] = 8'hA5; exp_mem[5] = 8'hA5;
    reset_n = 1'b0; spi_start_flag = 1'b0; spi_addr = 7'h00; spi_addr_valid = 1'b0;
    spi_rw = 1'b0; spi_wr_data = 8'h00; spi_wr_valid = 1'b0;
    int_req = 1'b0; int_we = 1'b0; int_addr = 7'h00; int_wdata = 8'h00;
    int_pend = 1'b0; rd_pend = 1'b0; hold_prev = 1'b0; int_rate = 100; int_wr_ok = 1'b0;
    spi_exp = 8'h00; rd_exp = 8'h00;
    repeat (3) cyc();
    smp(); check_all_zero("reset");
    cyc(); reset_n = 1'b1;

    spi_read(7'h05, 1'b0, 1'b0);
    int_rate = 60; int_wr_ok = 1'b1;
    spi_write(7'h12, 8'h3C, 1'b0, 1'b1);
    spi_read(7'h12, 1'b0, 1'b0);
    spi_read(7'h03, 1'b1, 1'b0);
    spi_read(7'h7F, 1'b0, 1'b0);
    spi_read(7'h07, 1'b0, 1'b1);
    spi_read(7'h08, 1'b0, 1'b0);
    spi_write(7'h30, 8'h44, 1'b1, 1'b0);
    spi_read(7'h30, 1'b0, 1'b0);
    reset_mid_write();
    spi_read(7'h20, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int_rate = $urandom_range(0, 100);
      if ($urandom_range(0, 1) == 1)
        spi_read(7'($urandom_range(0, 79)), 1'b0, 1'($urandom_range(0, 1)));
      else
        spi_write(7'($urandom_range(0, 79)), 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0);
    end

    spi_addr_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(); int_drive(1'b0); smp(); int_check(1'b0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
